// File: rtl/capture_pkg.sv
// Shared state encoding, default record signature and beat-count helper
// for the trigger capture buffer.
package capture_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDump    = 2'd3
    } capState_e;

    localparam logic [31:0] DefaultHeader = 32'hFF807F00;

    function automatic int unsigned beatsPerWord(input int unsigned wordW, input int unsigned outW);
        return wordW / outW;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits WORD_W-bit words into OUT_W-bit beats, MSB first, with a one-word skid
// register so a new word can be accepted while the current one is still draining.
module word_serializer
    import capture_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OUT_W  = 8
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Flush,
    input  logic [WORD_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [OUT_W-1:0]  OutData,
    output logic              OutValid,
    input  logic              OutReady
);

    localparam int unsigned Beats = beatsPerWord(WORD_W, OUT_W);
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastIdx = BeatW'(Beats - 1);

    logic [WORD_W-1:0] curQ, curD, skidQ, skidD;
    logic              curValidQ, curValidD, skidValidQ, skidValidD;
    logic [BeatW-1:0]  beatQ, beatD;
    logic              outXfer, inXfer;

    assign InReady  = !skidValidQ;
    assign OutValid = curValidQ;
    assign OutData  = curQ[WORD_W-1 -: OUT_W];

    always_comb begin
        curD       = curQ;
        curValidD  = curValidQ;
        beatD      = beatQ;
        skidD      = skidQ;
        skidValidD = skidValidQ;
        outXfer    = curValidQ && OutReady;
        inXfer     = InValid && !skidValidQ;
        if (Flush) begin
            curD       = '0;
            curValidD  = 1'b0;
            skidValidD = 1'b0;
            beatD      = '0;
        end else if (!curValidQ || (outXfer && beatQ == LastIdx)) begin
            // Current word is free this cycle: refill from skid first to keep order.
            beatD = '0;
            if (skidValidQ) begin
                curD       = skidQ;
                curValidD  = 1'b1;
                skidValidD = 1'b0;
            end else if (inXfer) begin
                curD      = InData;
                curValidD = 1'b1;
            end else begin
                curValidD = 1'b0;
            end
        end else begin
            if (outXfer) begin
                curD  = curQ << OUT_W;
                beatD = beatQ + 1'b1;
            end
            if (inXfer) begin
                skidD      = InData;
                skidValidD = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            curQ       <= '0;
            curValidQ  <= 1'b0;
            beatQ      <= '0;
            skidQ      <= '0;
            skidValidQ <= 1'b0;
        end else begin
            curQ       <= curD;
            curValidQ  <= curValidD;
            beatQ      <= beatD;
            skidQ      <= skidD;
            skidValidQ <= skidValidD;
        end
    end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Circular ADC record buffer with programmable pre-trigger depth; after the record
// completes it streams a header word plus the record, oldest first, as OUT_W beats.
module trigger_capture_buffer
    import capture_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned OUT_W    = 8,
    parameter logic [31:0] HEADER   = DefaultHeader
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic                         Arm,
    input  logic                         Abort,
    input  logic                         Trigger,
    input  logic [ADDR_W-1:0]            PreTrigLen,
    input  logic [CHANNELS*SAMPLE_W-1:0] SampleIn,
    input  logic                         SampleValid,
    output logic [OUT_W-1:0]             OutData,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic                         Done,
    output logic [1:0]                   State
);

    localparam int unsigned WordW      = CHANNELS * SAMPLE_W;
    localparam int unsigned Beats      = beatsPerWord(WordW, OUT_W);
    localparam int unsigned TotalBeats = (DEPTH + 1) * Beats;
    localparam int unsigned BeatCntW   = $clog2(TotalBeats);
    localparam logic [BeatCntW-1:0] LastBeatIdx = BeatCntW'(TotalBeats - 1);
    localparam logic [ADDR_W:0]     DepthCnt    = (ADDR_W + 1)'(DEPTH);
    localparam logic [WordW-1:0]    HeaderWord  = WordW'(HEADER);

    capState_e           stateQ, stateD;
    logic [ADDR_W-1:0]   preLenQ, preLenD, fillQ, fillD, wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
    logic [ADDR_W:0]     postCntQ, postCntD, rdIssuedQ, rdIssuedD, postTarget;
    logic                rdValidQ, rdValidD, hdrDoneQ, hdrDoneD, trigPrevQ, doneQ;
    logic [BeatCntW-1:0] beatCntQ, beatCntD;
    logic [WordW-1:0]    mem [DEPTH];
    logic [WordW-1:0]    rdDataQ, serInData;
    logic                memWe, rdEn, trigRise, serInValid, serInReady, serInXfer;
    logic                ramXfer, outXfer, lastXfer, serFlush;

    assign trigRise   = Trigger && !trigPrevQ;
    assign postTarget = DepthCnt - {1'b0, preLenQ};
    assign serInData  = hdrDoneQ ? rdDataQ : HeaderWord;
    assign serInValid = (stateQ == StDump) && (!hdrDoneQ || rdValidQ);
    assign serInXfer  = serInValid && serInReady;
    assign ramXfer    = serInXfer && hdrDoneQ;
    // Prefetch: keep one word waiting in rdDataQ so the serializer never starves.
    assign rdEn       = (stateQ == StDump) && (rdIssuedQ != DepthCnt) && (!rdValidQ || ramXfer);
    assign outXfer    = OutValid && OutReady;
    assign lastXfer   = (stateQ == StDump) && outXfer && (beatCntQ == LastBeatIdx);
    assign serFlush   = Abort || (stateQ != StDump);
    assign Done       = doneQ;
    assign State      = stateQ;

    // PreTrigLen is ADDR_W wide, so it can never exceed DEPTH-1.
    always_comb begin
        stateD    = stateQ;
        preLenD   = preLenQ;
        fillD     = fillQ;
        wrPtrD    = wrPtrQ;
        postCntD  = postCntQ;
        rdPtrD    = rdPtrQ;
        rdIssuedD = rdIssuedQ;
        rdValidD  = rdValidQ;
        hdrDoneD  = hdrDoneQ;
        beatCntD  = beatCntQ;
        memWe     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (Arm) begin
                    stateD  = StArmed;
                    preLenD = PreTrigLen;
                    fillD   = '0;
                    wrPtrD  = '0;
                end
            end
            StArmed: begin
                if (SampleValid) begin
                    memWe  = 1'b1;
                    wrPtrD = wrPtrQ + 1'b1;
                    if (fillQ < preLenQ) fillD = fillQ + 1'b1;
                end
                if (trigRise && fillQ >= preLenQ) begin
                    stateD   = StCapture;
                    postCntD = {{ADDR_W{1'b0}}, SampleValid};
                end
            end
            StCapture: begin
                if (postCntQ == postTarget) begin
                    stateD    = StDump;
                    rdPtrD    = wrPtrQ;
                    rdIssuedD = '0;
                    rdValidD  = 1'b0;
                    hdrDoneD  = 1'b0;
                    beatCntD  = '0;
                end else if (SampleValid) begin
                    memWe    = 1'b1;
                    wrPtrD   = wrPtrQ + 1'b1;
                    postCntD = postCntQ + 1'b1;
                end
            end
            StDump: begin
                if (rdEn) begin
                    rdPtrD    = rdPtrQ + 1'b1;
                    rdIssuedD = rdIssuedQ + 1'b1;
                    rdValidD  = 1'b1;
                end else if (ramXfer) begin
                    rdValidD = 1'b0;
                end
                if (serInXfer && !hdrDoneQ) hdrDoneD = 1'b1;
                if (outXfer) beatCntD = beatCntQ + 1'b1;
                if (lastXfer) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
        if (Abort) stateD = StIdle;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stateQ    <= StIdle;
            preLenQ   <= '0;
            fillQ     <= '0;
            wrPtrQ    <= '0;
            postCntQ  <= '0;
            rdPtrQ    <= '0;
            rdIssuedQ <= '0;
            rdValidQ  <= 1'b0;
            hdrDoneQ  <= 1'b0;
            beatCntQ  <= '0;
            trigPrevQ <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            preLenQ   <= preLenD;
            fillQ     <= fillD;
            wrPtrQ    <= wrPtrD;
            postCntQ  <= postCntD;
            rdPtrQ    <= rdPtrD;
            rdIssuedQ <= rdIssuedD;
            rdValidQ  <= rdValidD;
            hdrDoneQ  <= hdrDoneD;
            beatCntQ  <= beatCntD;
            trigPrevQ <= Trigger;
            doneQ     <= lastXfer && !Abort;
        end
    end

    // Simple dual-port RAM, registered read.
    always_ff @(posedge Clock) begin
        if (memWe) mem[wrPtrQ] <= SampleIn;
        if (rdEn) rdDataQ <= mem[rdPtrQ];
    end

    word_serializer #(
        .WORD_W (WordW),
        .OUT_W  (OUT_W)
    ) uSerializer (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .Flush    (serFlush),
        .InData   (serInData),
        .InValid  (serInValid),
        .InReady  (serInReady),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Scoreboard bench for trigger_capture_buffer with a 16-word record.
module tb_trigger_capture_buffer;

    localparam int unsigned Depth = 16;
    localparam int unsigned AddrW = 4;

    logic             Clock = 1'b0;
    logic             ResetN = 1'b0;
    logic             Arm = 1'b0;
    logic             Abort = 1'b0;
    logic             Trigger = 1'b0;
    logic             SampleValid = 1'b0;
    logic             OutReady = 1'b1;
    logic [AddrW-1:0] PreTrigLen = '0;
    logic [31:0]      SampleIn = '0;
    logic [7:0]       OutData;
    logic             OutValid;
    logic             Done;
    logic [1:0]       State;

    int         total = 0;
    int         bad = 0;
    int         doneCount = 0;
    bit         sbOn = 1'b1;
    bit         randReady = 1'b0;
    logic [7:0] expQ[$];

    trigger_capture_buffer #(
        .DEPTH (Depth)
    ) dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .Arm         (Arm),
        .Abort       (Abort),
        .Trigger     (Trigger),
        .PreTrigLen  (PreTrigLen),
        .SampleIn    (SampleIn),
        .SampleValid (SampleValid),
        .OutData     (OutData),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .Done        (Done),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] sampleWord(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b, b ^ 8'h5A, b + 8'h80, ~b};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic pushRecord(input int firstOld);
        logic [31:0] h;
        logic [31:0] w;
        h = 32'hFF807F00;
        for (int i = 0; i < 4; i++) expQ.push_back(h[31-8*i -: 8]);
        for (int k = 0; k < int'(Depth); k++) begin
            w = sampleWord(firstOld + k);
            for (int i = 0; i < 4; i++) expQ.push_back(w[31-8*i -: 8]);
        end
    endtask

    // Ramp n=0,1,.. every cycle; trigger pulses at trigA/trigB (or held from trigA).
    task automatic runRecord(input int pre, input int trigA, input int trigB, input bit holdTrig,
                             input bit armInDump, input int firstOld);
        int d0;
        int n;
        bit done;
        bit armed;
        d0 = doneCount;
        armed = 1'b0;
        PreTrigLen = AddrW'(pre);
        Arm = 1'b1;
        step();
        Arm = 1'b0;
        check("armed_state", State, 1);
        pushRecord(firstOld);
        n = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 800 && !done; cyc++) begin
            SampleIn = sampleWord(n);
            SampleValid = 1'b1;
            if (holdTrig) Trigger = (n >= trigA);
            else Trigger = (n == trigA) || (n == trigB);
            Arm = armInDump && !armed && (State == 2'd3);
            if (Arm) armed = 1'b1;
            step();
            n++;
            if (Done) done = 1'b1;
        end
        SampleValid = 1'b0;
        Trigger = 1'b0;
        Arm = 1'b0;
        check("done_seen", done, 1);
        check("done_state_idle", State, 0);
        check("done_outvalid_low", OutValid, 0);
        step();
        step();
        check("done_state_stays_idle", State, 0);
        check("done_pulse_count", doneCount - d0, 1);
        check("queue_drained", expQ.size(), 0);
    endtask

    task automatic armAndReachDump(output bit reached);
        PreTrigLen = AddrW'(4);
        Arm = 1'b1;
        step();
        Arm = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            SampleIn = sampleWord(n);
            SampleValid = 1'b1;
            Trigger = (n == 5);
            step();
            if (State == 2'd3) reached = 1'b1;
        end
        SampleValid = 1'b0;
        Trigger = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            #1;
            OutReady = randReady ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // Monitor: pops expected beats on every transfer and checks stall stability.
    initial begin
        logic [7:0] heldData;
        bit stalled;
        logic [7:0] want;
        stalled = 1'b0;
        heldData = '0;
        forever begin
            @(negedge Clock);
            if (!ResetN) begin
                stalled = 1'b0;
            end else begin
                if (Done) doneCount++;
                if (OutValid) begin
                    if (stalled) check("stall_hold", OutData, heldData);
                    if (OutReady) begin
                        stalled = 1'b0;
                        if (sbOn) begin
                            if (expQ.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_beat: got %0h expected none", OutData);
                            end else begin
                                want = expQ.pop_front();
                                check("beat", OutData, want);
                            end
                        end
                    end else begin
                        stalled = 1'b1;
                        heldData = OutData;
                    end
                end else begin
                    if (stalled && sbOn) check("valid_dropped_in_stall", OutValid, 1);
                    stalled = 1'b0;
                end
            end
        end
    end

    initial begin
        int d0;
        bit reached;
        ResetN = 1'b0;
        step();
        step();
        check("reset_state", State, 0);
        check("reset_outvalid", OutValid, 0);
        check("reset_done", Done, 0);
        check("reset_outdata", OutData, 0);
        ResetN = 1'b1;
        step();

        // Basic record: pre=4, trigger on sample 10 -> words 6..21.
        runRecord(4, 10, -1, 1'b0, 1'b0, 6);
        // Early edge dropped, second edge accepted -> words 2..17.
        runRecord(4, 2, 6, 1'b0, 1'b0, 2);
        // No pre-trigger history -> words 3..18.
        runRecord(0, 3, -1, 1'b0, 1'b0, 3);
        // Back-pressure: same bytes as the basic record.
        randReady = 1'b1;
        runRecord(4, 10, -1, 1'b0, 1'b0, 6);
        randReady = 1'b0;
        // Max pre-trigger, trigger held high, Arm pulsed during dump -> words 0..15.
        runRecord(15, 15, -1, 1'b1, 1'b1, 0);

        // Arm and Abort together in IDLE: Abort wins.
        PreTrigLen = AddrW'(4);
        Arm = 1'b1;
        Abort = 1'b1;
        step();
        Arm = 1'b0;
        Abort = 1'b0;
        check("arm_abort_same_cycle", State, 0);

        // Abort during capture.
        sbOn = 1'b0;
        d0 = doneCount;
        Arm = 1'b1;
        step();
        Arm = 1'b0;
        for (int n = 0; n < 6; n++) begin
            SampleIn = sampleWord(n);
            SampleValid = 1'b1;
            Trigger = (n == 5);
            step();
        end
        check("capture_reached", State, 2);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        SampleValid = 1'b0;
        Trigger = 1'b0;
        check("abort_capture_state", State, 0);
        check("abort_capture_outvalid", OutValid, 0);

        // Abort during dump.
        armAndReachDump(reached);
        check("dump_reached", reached, 1);
        repeat (6) step();
        check("dump_streaming", OutValid, 1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("abort_dump_state", State, 0);
        check("abort_dump_outvalid", OutValid, 0);
        step();
        step();
        check("abort_no_done", doneCount - d0, 0);
        expQ.delete();
        sbOn = 1'b1;

        // Re-arm after aborts.
        runRecord(4, 10, -1, 1'b0, 1'b0, 6);

        // Asynchronous reset in the middle of a dump.
        sbOn = 1'b0;
        armAndReachDump(reached);
        check("dump_reached_for_reset", reached, 1);
        repeat (5) step();
        #2;
        ResetN = 1'b0;
        #1;
        check("async_reset_state", State, 0);
        check("async_reset_outvalid", OutValid, 0);
        check("async_reset_done", Done, 0);
        check("async_reset_outdata", OutData, 0);
        step();
        #2;
        ResetN = 1'b1;
        step();
        check("post_reset_idle", State, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
